// File: rtl/door_lock_pkg.sv
// Shared types and default constants for the door lock controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package door_lock_pkg;

    // Controller states. CHECK is a single-cycle compare slot between the
    // accept edge and the verdict.
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CHECK    = 2'd1,
        S_UNLOCKED = 2'd2,
        S_LOCKOUT  = 2'd3
    } state_e;

    localparam int          DEF_PASS_W         = 16;
    localparam int          DEF_MAX_TRIES      = 3;
    localparam int          DEF_UNLOCK_CYCLES  = 1000;
    localparam int          DEF_LOCKOUT_CYCLES = 5000;
    localparam logic [15:0] DEF_CODE           = 16'hFFFF;

    // Used to size the shared timer for the longer of the two hold periods.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Down-counter shared by the UNLOCKED and LOCKOUT hold periods.
// Latency: load takes effect on the next edge; done is a decode of the count register.
// Backpressure: none; decrements every enabled cycle and saturates at zero.
//
// Ports:
//   clk, rst_n  - clock and synchronous active-high reset (clears count)
//   load_vld    - load strobe, wins over decrement
//   load_val    - value loaded on load_vld
//   dec_en      - decrement by one this cycle (saturating at zero)
//   done        - the current cycle is the last one of the loaded period
module lock_timer #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_vld,
    input  logic [W-1:0] load_val,
    input  logic         dec_en,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_vld) begin
            cnt_d = load_val;
        end else if (dec_en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A period loaded with N lasts N cycles: the cycle holding count 1 is the
    // last one. Count 0 also reads as done so a zero-length load cannot stall.
    assign done = (cnt_q == '0) || (cnt_q == W'(1));

endmodule

// File: rtl/door_lock_ctrl.sv
// Passcode door lock: compares attempts against a stored code, unlocks for a
// fixed hold, and locks out after MAX_TRIES consecutive failures.
// Latency: unlock rises 2 edges after the accept edge; try_fail 1 edge after.
// Backpressure: attempt_ready high only in IDLE; other-state attempts stall.
//
// Ports:
//   clk                         - single clock, rising edge
//   rst_n                       - synchronous reset, ACTIVE HIGH despite the name
//   attempt_valid/_code/_ready  - valid/ready attempt channel
//   prog_valid/prog_code        - replace stored code (honoured only while unlocked)
//   lock_now                    - relock immediately while unlocked
//   unlock, try_fail, lockout   - registered status outputs
//   fail_count                  - consecutive failed attempts
module door_lock_ctrl
    import door_lock_pkg::*;
#(
    parameter int                PASS_W         = DEF_PASS_W,
    parameter int                MAX_TRIES      = DEF_MAX_TRIES,
    parameter int                UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
    parameter int                LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter logic [PASS_W-1:0] DEFAULT_CODE   = DEF_CODE
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             attempt_valid,
    input  logic [PASS_W-1:0]                attempt_code,
    output logic                             attempt_ready,
    input  logic                             prog_valid,
    input  logic [PASS_W-1:0]                prog_code,
    input  logic                             lock_now,
    output logic                             unlock,
    output logic                             try_fail,
    output logic                             lockout,
    output logic [$clog2(MAX_TRIES+1)-1:0]   fail_count
);

    localparam int CNT_W = $clog2(MAX_TRIES + 1);
    localparam int TMR_W = $clog2(max_int(UNLOCK_CYCLES, LOCKOUT_CYCLES) + 1);

    state_e              state_q, state_d;
    logic [PASS_W-1:0]   code_q, code_d;
    logic [PASS_W-1:0]   cand_q, cand_d;
    logic [CNT_W-1:0]    fail_cnt_q, fail_cnt_d;
    logic                attempt_ready_q, attempt_ready_d;
    logic                unlock_q, unlock_d;
    logic                lockout_q, lockout_d;
    logic                try_fail_q, try_fail_d;

    logic                tmr_load;
    logic [TMR_W-1:0]    tmr_val;
    logic                tmr_dec;
    logic                tmr_done;

    logic                accept;
    logic                prog_take;
    logic                code_match;
    logic [CNT_W-1:0]    fail_next;

    assign accept     = attempt_valid && attempt_ready_q;
    assign prog_take  = prog_valid && (state_q == S_UNLOCKED);
    assign code_match = (cand_q == code_q);
    assign fail_next  = fail_cnt_q + CNT_W'(1);
    assign tmr_dec    = (state_q == S_UNLOCKED) || (state_q == S_LOCKOUT);

    lock_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_vld (tmr_load),
        .load_val (tmr_val),
        .dec_en   (tmr_dec),
        .done     (tmr_done)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q         <= S_IDLE;
            code_q          <= DEFAULT_CODE;
            cand_q          <= '0;
            fail_cnt_q      <= '0;
            attempt_ready_q <= 1'b0;
            unlock_q        <= 1'b0;
            lockout_q       <= 1'b0;
            try_fail_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            code_q          <= code_d;
            cand_q          <= cand_d;
            fail_cnt_q      <= fail_cnt_d;
            attempt_ready_q <= attempt_ready_d;
            unlock_q        <= unlock_d;
            lockout_q       <= lockout_d;
            try_fail_q      <= try_fail_d;
        end
    end

    // Next state and timer control.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (code_match) begin
                    state_d  = S_UNLOCKED;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(UNLOCK_CYCLES);
                end else if (fail_next == CNT_W'(MAX_TRIES)) begin
                    state_d  = S_LOCKOUT;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(LOCKOUT_CYCLES);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_UNLOCKED: begin
                if (lock_now || tmr_done) begin
                    state_d = S_IDLE;
                end
            end
            S_LOCKOUT: begin
                if (tmr_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs and datapath. unlock/lockout are registered images of the state,
    // so they trail it by one cycle. attempt_ready is held off for that one
    // trailing cycle so it never overlaps unlock or lockout.
    always_comb begin
        cand_d          = cand_q;
        code_d          = code_q;
        fail_cnt_d      = fail_cnt_q;
        attempt_ready_d = (state_d == S_IDLE) &&
                          (state_q != S_UNLOCKED) && (state_q != S_LOCKOUT);
        unlock_d        = (state_q == S_UNLOCKED);
        lockout_d       = (state_q == S_LOCKOUT);
        try_fail_d      = (state_q == S_CHECK) && !code_match;

        if (accept) begin
            cand_d = attempt_code;
        end
        if (prog_take) begin
            code_d = prog_code;
        end

        if (state_q == S_CHECK) begin
            if (code_match) begin
                fail_cnt_d = '0;
            end else if (fail_cnt_q < CNT_W'(MAX_TRIES)) begin
                fail_cnt_d = fail_next;
            end
        end

        // Clear the count on the edge lockout drops, so it reads MAX_TRIES for
        // the whole time lockout is visible. attempt_ready is low in this cycle,
        // so no new attempt can race the clear.
        if (lockout_q && (state_q != S_LOCKOUT)) begin
            fail_cnt_d = '0;
        end
    end

    assign attempt_ready = attempt_ready_q;
    assign unlock        = unlock_q;
    assign lockout       = lockout_q;
    assign try_fail      = try_fail_q;
    assign fail_count    = fail_cnt_q;

    // Attempts are only taken in IDLE and programming only in UNLOCKED, so an
    // attempt can never be compared against a code written on the same edge.
    a_no_prog_on_accept: assert property (@(posedge clk) disable iff (rst_n)
        !(accept && prog_take));

    a_fail_cnt_bound: assert property (@(posedge clk) disable iff (rst_n)
        fail_cnt_q <= CNT_W'(MAX_TRIES));

endmodule

// File: tb/tb_door_lock_ctrl.sv
module tb_door_lock_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        attempt_valid;
    logic [15:0] attempt_code;
    logic        attempt_ready;
    logic        prog_valid;
    logic [15:0] prog_code;
    logic        lock_now;
    logic        unlock;
    logic        try_fail;
    logic        lockout;
    logic [1:0]  fail_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    door_lock_ctrl #(
        .PASS_W         (16),
        .MAX_TRIES      (3),
        .UNLOCK_CYCLES  (4),
        .LOCKOUT_CYCLES (8),
        .DEFAULT_CODE   (16'hFFFF)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .attempt_valid (attempt_valid),
        .attempt_code  (attempt_code),
        .attempt_ready (attempt_ready),
        .prog_valid    (prog_valid),
        .prog_code     (prog_code),
        .lock_now      (lock_now),
        .unlock        (unlock),
        .try_fail      (try_fail),
        .lockout       (lockout),
        .fail_count    (fail_count)
    );

    typedef struct {
        logic        rst;
        logic        av;
        logic [15:0] ac;
        logic        pv;
        logic [15:0] pc;
        logic        ln;
        logic        e_rdy;
        logic        e_unl;
        logic        e_lko;
        logic        e_tf;
        logic [1:0]  e_fc;
    } vec_t;

    vec_t vecs[$];

    // Inputs are applied before an edge; expectations are the outputs after it.
    task automatic add(input logic rst, input logic av, input logic [15:0] ac,
                       input logic pv, input logic [15:0] pc, input logic ln,
                       input logic e_rdy, input logic e_unl, input logic e_lko,
                       input logic e_tf, input logic [1:0] e_fc);
        vec_t v;
        v.rst = rst; v.av = av; v.ac = ac; v.pv = pv; v.pc = pc; v.ln = ln;
        v.e_rdy = e_rdy; v.e_unl = e_unl; v.e_lko = e_lko; v.e_tf = e_tf; v.e_fc = e_fc;
        vecs.push_back(v);
    endtask

    // Idle-input shorthand.
    task automatic add_idle(input logic e_rdy, input logic e_unl, input logic e_lko,
                            input logic e_tf, input logic [1:0] e_fc);
        add(0, 0, 16'h0, 0, 16'h0, 0, e_rdy, e_unl, e_lko, e_tf, e_fc);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int lat;
        int hi;
        logic [5:0] act;
        logic [5:0] exp;

        rst_n = 1'b1; attempt_valid = 1'b0; attempt_code = '0;
        prog_valid = 1'b0; prog_code = '0; lock_now = 1'b0;

        // Reset state
        add(1, 0, 16'h0, 0, 16'h0, 0, 0, 0, 0, 0, 0);

        // Correct default code: unlock 2 edges after accept, held 4 cycles
        add(0, 1, 16'hFFFF, 0, 16'h0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 16'hFFFF, 0, 16'h0, 0, 0, 0, 0, 0, 0);
        add_idle(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add_idle(0, 1, 0, 0, 0);
        add_idle(1, 0, 0, 0, 0);

        // Three wrong attempts -> lockout for 8 cycles; an attempt held
        // through lockout stalls and is taken afterwards
        add(0, 1, 16'h1234, 0, 16'h0, 0, 0, 0, 0, 0, 0);
        add_idle(1, 0, 0, 1, 1);
        add(0, 1, 16'h1234, 0, 16'h0, 0, 0, 0, 0, 0, 1);
        add_idle(1, 0, 0, 1, 2);
        add(0, 1, 16'h1234, 0, 16'h0, 0, 0, 0, 0, 0, 2);
        add_idle(0, 0, 0, 1, 3);
        for (int i = 0; i < 8; i++) add(0, 1, 16'hFFFF, 0, 16'h0, 0, 0, 0, 1, 0, 3);
        add(0, 1, 16'hFFFF, 0, 16'h0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 16'hFFFF, 0, 16'h0, 0, 0, 0, 0, 0, 0);
        add_idle(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add_idle(0, 1, 0, 0, 0);
        add_idle(1, 0, 0, 0, 0);

        // Two wrong then correct: fail_count back to 0 and unlock
        add(0, 1, 16'h1234, 0, 16'h0, 0, 0, 0, 0, 0, 0);
        add_idle(1, 0, 0, 1, 1);
        add(0, 1, 16'h1234, 0, 16'h0, 0, 0, 0, 0, 0, 1);
        add_idle(1, 0, 0, 1, 2);
        add(0, 1, 16'hFFFF, 0, 16'h0, 0, 0, 0, 0, 0, 2);
        add_idle(0, 0, 0, 0, 0);
        add_idle(0, 1, 0, 0, 0);

        // Program A5A5 together with lock_now, then old code fails, new unlocks
        add(0, 0, 16'h0, 1, 16'hA5A5, 1, 0, 1, 0, 0, 0);
        add_idle(1, 0, 0, 0, 0);
        add(0, 1, 16'hFFFF, 0, 16'h0, 0, 0, 0, 0, 0, 0);
        add_idle(1, 0, 0, 1, 1);
        add(0, 1, 16'hA5A5, 0, 16'h0, 0, 0, 0, 0, 0, 1);
        add_idle(0, 0, 0, 0, 0);
        add_idle(0, 1, 0, 0, 0);
        add(0, 0, 16'h0, 0, 16'h0, 1, 0, 1, 0, 0, 0);
        add_idle(1, 0, 0, 0, 0);

        // prog_valid (and lock_now) in IDLE ignored; 0000 rejected
        add(0, 0, 16'h0, 1, 16'h0000, 1, 1, 0, 0, 0, 0);
        add(0, 1, 16'h0000, 0, 16'h0, 0, 0, 0, 0, 0, 0);
        add_idle(1, 0, 0, 1, 1);

        // Reach lockout, reset on its third cycle, default code restored
        add(0, 1, 16'h1234, 0, 16'h0, 0, 0, 0, 0, 0, 1);
        add_idle(1, 0, 0, 1, 2);
        add(0, 1, 16'h1234, 0, 16'h0, 0, 0, 0, 0, 0, 2);
        add_idle(0, 0, 0, 1, 3);
        add_idle(0, 0, 1, 0, 3);
        add_idle(0, 0, 1, 0, 3);
        add(1, 0, 16'h0, 0, 16'h0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 16'hFFFF, 0, 16'h0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 16'hFFFF, 0, 16'h0, 0, 0, 0, 0, 0, 0);
        add_idle(0, 0, 0, 0, 0);
        add_idle(0, 1, 0, 0, 0);

        foreach (vecs[i]) begin
            rst_n         = vecs[i].rst;
            attempt_valid = vecs[i].av;
            attempt_code  = vecs[i].ac;
            prog_valid    = vecs[i].pv;
            prog_code     = vecs[i].pc;
            lock_now      = vecs[i].ln;
            tick();
            act = {attempt_ready, unlock, lockout, try_fail, fail_count};
            exp = {vecs[i].e_rdy, vecs[i].e_unl, vecs[i].e_lko, vecs[i].e_tf, vecs[i].e_fc};
            chk($sformatf("vec%0d{rdy,unl,lko,tf,fc}", i), 32'(act), 32'(exp));
        end

        // Reset in the middle of UNLOCKED: outputs drop at once, no residual pulse
        rst_n = 1'b1; attempt_valid = 1'b0; prog_valid = 1'b0; lock_now = 1'b0;
        tick();
        chk("rst_mid_unlock", 32'({attempt_ready, unlock, lockout, try_fail, fail_count}), 32'h0);
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("no_residual%0d", i), 32'({unlock, lockout, try_fail}), 32'h0);
        end

        // Held attempt: bounded wait for ready, then latency and hold length
        attempt_valid = 1'b1; attempt_code = 16'hFFFF;
        w = 0;
        while (!attempt_ready && w < 20) begin
            tick();
            w++;
        end
        chk("ready_wait", 32'(attempt_ready), 32'h1);
        tick();
        attempt_valid = 1'b0;
        lat = 0;
        while (!unlock && lat < 20) begin
            tick();
            lat++;
        end
        chk("unlock_latency", 32'(lat), 32'd2);
        chk("unlock_fail_cnt", 32'(fail_count), 32'd0);
        hi = 0;
        while (unlock && hi < 20) begin
            hi++;
            tick();
        end
        chk("unlock_hold", 32'(hi), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
